// File: rtl/reg_dump_reader_pkg.sv
// rtl/reg_dump_reader_pkg.sv - shared sizing constants and FSM encoding for the register dump reader
package reg_dump_reader_pkg;

    localparam int NUM_REGS   = 32;
    localparam int DEF_ADDR_W = $clog2(NUM_REGS);
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_SEND = 2'd2,
        ST_FIN  = 2'd3
    } dump_state_t;

endpackage

// File: rtl/reg_dump_out_stage.sv
// rtl/reg_dump_out_stage.sv - output word register, held stable under downstream backpressure
module reg_dump_out_stage #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              load,
    input  logic              drop,
    input  logic [DATA_W-1:0] cap_data,
    input  logic [ADDR_W-1:0] cap_index,
    input  logic              cap_last,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] index,
    output logic              last,
    output logic              valid
);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            data  <= '0;
            index <= '0;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= cap_data;
            index <= cap_index;
            last  <= cap_last;
            valid <= 1'b1;
        end else if (drop) begin
            // data/index keep their last value; only the qualifiers fall
            last  <= 1'b0;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - scans a register range through the display-select port and streams the words out
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter bit SKIP_X0 = 1'b0
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic [ADDR_W-1:0] iFirst,
    input  logic [ADDR_W-1:0] iLast,
    output logic [ADDR_W-1:0] oRegSelect,
    input  logic [DATA_W-1:0] iRegData,
    output logic [DATA_W-1:0] oData,
    output logic [ADDR_W-1:0] oIndex,
    output logic              oValid,
    input  logic              iReady,
    output logic              oLast,
    output logic              oBusy,
    output logic              oDone,
    output logic              oError
);

    localparam logic [ADDR_W-1:0] ONE = 1;

    dump_state_t       state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] start_idx;
    logic              empty_range;
    logic              abort_act;
    logic              load_word;
    logic              drop_word;

    // x0 is hardwired zero, so skipping it may leave nothing to send
    assign start_idx   = (SKIP_X0 && (iFirst == '0)) ? ONE : iFirst;
    assign empty_range = SKIP_X0 && (iLast == '0);

    assign abort_act = iAbort && (state != ST_IDLE);
    assign load_word = (state == ST_SEL) && !iAbort;
    assign drop_word = abort_act || ((state == ST_SEND) && iReady);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            last_q     <= '0;
            oRegSelect <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oError     <= 1'b0;
        end else begin
            oDone  <= 1'b0;
            oError <= 1'b0;
            if (abort_act) begin
                state <= ST_IDLE;
                oBusy <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (iStart) begin
                            if (iFirst <= iLast) begin
                                last_q     <= iLast;
                                idx        <= start_idx;
                                oRegSelect <= start_idx;
                                oBusy      <= 1'b1;
                                state      <= empty_range ? ST_FIN : ST_SEL;
                            end else begin
                                oError <= 1'b1;
                            end
                        end
                    end
                    ST_SEL: begin
                        state <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (iReady) begin
                            // compare before incrementing so a range ending at the top index never wraps
                            if (idx == last_q) begin
                                state <= ST_FIN;
                            end else begin
                                idx        <= idx + ONE;
                                oRegSelect <= idx + ONE;
                                state      <= ST_SEL;
                            end
                        end
                    end
                    ST_FIN: begin
                        oDone <= 1'b1;
                        oBusy <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    reg_dump_out_stage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_stage (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .load      (load_word),
        .drop      (drop_word),
        .cap_data  (iRegData),
        .cap_index (idx),
        .cap_last  (idx == last_q),
        .data      (oData),
        .index     (oIndex),
        .last      (oLast),
        .valid     (oValid)
    );

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side client of the register file's auxiliary display-select read port.
- On request, scans a range of architectural registers and streams each value out over a valid/ready word interface.
- Stream feeds the debug UART / on-screen register display.
- Owns only the select port; never writes registers and never disturbs the pipeline read ports.

Parameters:
ADDR_W, 5, register index width (32 registers)
DATA_W, 32, register word width
SKIP_X0, 0, when 1, index 0 is never emitted (hardwired zero register)

Ports:
iCLK  in  1  system clock, all state updates on rising edge
iRST_n  in  1  asynchronous active-low reset
iStart  in  1  one-cycle request to begin a dump; sampled only in IDLE
iAbort  in  1  cancels an active dump; dominates iStart
iFirst  in  ADDR_W  first register index, latched on accepted iStart
iLast  in  ADDR_W  last register index (inclusive), latched on accepted iStart
oRegSelect  out  ADDR_W  registered select driven to the register file display-select input
iRegData  in  DATA_W  combinational read data returned for oRegSelect
oData  out  DATA_W  captured register value
oIndex  out  ADDR_W  index of the word on oData
oValid  out  1  oData/oIndex/oLast valid
iReady  in  1  downstream accepts the word when oValid & iReady
oLast  out  1  marks the final word of the dump
oBusy  out  1  high from accepted iStart until return to IDLE
oDone  out  1  one-cycle pulse on normal completion
oError  out  1  one-cycle pulse when a request is rejected for iFirst > iLast

Behaviour:
- Reset (iRST_n=0, asynchronous): all outputs 0, FSM=IDLE, latched range=0.
- States: IDLE, SEL, SEND, FIN.
- IDLE:
  - iStart & iFirst<=iLast: latch range; idx = first emitted index; oRegSelect<=idx; oBusy<=1; go SEL.
  - First emitted index is iFirst, or iFirst+1 when SKIP_X0 and iFirst==0.
  - SKIP_X0 leaves an empty range (iFirst=iLast=0): no words; go FIN.
  - iStart & iFirst>iLast: oError pulses the next cycle; stays IDLE; oBusy stays 0.
- SEL: oRegSelect is stable this cycle. At the edge: oData<=iRegData, oIndex<=idx, oLast<=(idx==last), oValid<=1; go SEND.
- SEND: oData/oIndex/oLast held stable while oValid & !iReady.
  - On handshake with idx==last: oValid<=0, oLast<=0; go FIN.
  - Otherwise: idx<=idx+1; oRegSelect<=idx+1; oValid<=0; go SEL.
- FIN: oDone=1 for exactly one cycle; oBusy<=0; go IDLE. A new iStart is accepted the cycle after FIN.
- Latency:
  - Accepted iStart at edge N: first oValid high in cycle N+2.
  - With iReady held high: one word per 2 cycles.
  - Dump of k words: oDone pulses k*2+1 cycles after acceptance.
- iStart while oBusy: ignored, no queuing.
- iAbort in any non-IDLE state: next edge goes IDLE and clears oValid, oLast, oBusy. No oDone; any unaccepted word is dropped. iAbort in IDLE has no effect.
- idx is ADDR_W wide, compared to last before increment, never wraps. iLast=31 terminates cleanly at 31.
- iFirst/iLast changes while busy have no effect.
- Values are sampled live; a concurrent writeback between selects is reflected in later words. No snapshot guarantee.

Decomposition:
- Shared package (the core's parameter include): FSM state encoding constants, register count, default ADDR_W/DATA_W.
- Optional sub-module reg_dump_out_stage: holds oData/oIndex/oLast/oValid under backpressure.
- FSM and index counter stay in the top.

Test Plan:
- Full dump, iFirst=0, iLast=31, iReady=1, register file preloaded x[i]=i*0x11, x2=STACK_ADDRESS -> 32 words, indices 0..31, correct values; oLast only on index 31; oDone at cycle 65 after start.
- Backpressure, range 5..7, iReady low for 3 cycles on each word -> oData/oIndex stable while stalled; exactly 3 handshakes; no duplicates or skips.
- SKIP_X0=1: range 0..2 -> words for indices 1,2 only. Range 0..0 -> zero words, oDone pulse, no oValid.
- Reject, iFirst=9, iLast=3 -> oError one-cycle pulse, oBusy stays 0, no oValid, no oDone.
- Abort after 2nd word of range 0..31 -> next edge oValid=0 and oBusy=0, no oDone; subsequent iStart range 4..4 yields a single word, index 4.
- Async reset asserted mid-SEND -> all outputs 0 immediately without a clock edge; after release, FSM is IDLE and iStart ignored while iRST_n=0.
